// File: rtl/imem_pkg.sv
// Shared widths and type definitions for the instruction-memory controller.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 9;
  localparam int unsigned IMEM_DATA_W = 16;

  // Controller phase: boot-load, then run until the next reset.
  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Which requester owns the read issued on port 1 in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DBG   = 2'd2
  } owner_t;

endpackage

// File: rtl/imem_if.sv
// Bundles the boot-load stream, CPU fetch, debug readback and SRAM port signals.
interface imem_if import imem_pkg::*; #(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) ();

  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              boot_done;

  logic              fetch_req;
  logic [15:0]       fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              addr_err;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_valid;
  logic [DATA_W-1:0] dbg_data;

  logic              sram_csb0;
  logic [ADDR_W-1:0] sram_addr0;
  logic [DATA_W-1:0] sram_din0;
  logic              sram_csb1;
  logic [ADDR_W-1:0] sram_addr1;
  logic [DATA_W-1:0] sram_dout1;

  // Controller side.
  modport slave (
    input  ld_valid, ld_data, ld_last, fetch_req, fetch_addr, dbg_req, dbg_addr,
           sram_dout1,
    output ld_ready, boot_done, fetch_gnt, fetch_valid, fetch_data, addr_err,
           dbg_gnt, dbg_valid, dbg_data, sram_csb0, sram_addr0, sram_din0,
           sram_csb1, sram_addr1
  );

  // Loader / CPU / debug / SRAM side.
  modport master (
    output ld_valid, ld_data, ld_last, fetch_req, fetch_addr, dbg_req, dbg_addr,
           sram_dout1,
    input  ld_ready, boot_done, fetch_gnt, fetch_valid, fetch_data, addr_err,
           dbg_gnt, dbg_valid, dbg_data, sram_csb0, sram_addr0, sram_din0,
           sram_csb1, sram_addr1
  );

endinterface

// File: rtl/imem_rd_arb.sv
// Read-port arbiter: fetch has priority, debug is guaranteed a slot after
// STARVE_N consecutive fetch wins. Also registers who owns the read in flight.
module imem_rd_arb import imem_pkg::*; #(
  parameter int unsigned STARVE_N = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   fetch_req,
  input  logic   dbg_req,
  output logic   fetch_gnt,
  output logic   dbg_gnt,
  output owner_t owner
);

  localparam int unsigned CNT_W = (STARVE_N < 1) ? 1 : $clog2(STARVE_N + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved   = (starve_cnt == CNT_W'(STARVE_N));
  assign dbg_gnt   = en && dbg_req && (!fetch_req || starved);
  assign fetch_gnt = en && fetch_req && !dbg_gnt;

  // Count fetch wins while debug waits; register the owner of this cycle's read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      owner      <= OWN_NONE;
    end else begin
      if (!dbg_req || dbg_gnt) begin
        starve_cnt <= '0;
      end else if (fetch_gnt && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (fetch_gnt) begin
        owner <= OWN_FETCH;
      end else if (dbg_gnt) begin
        owner <= OWN_DBG;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction SRAM controller: boot-loads the image through port 0, then
// serves CPU fetches and debug readback through port 1 with 1-cycle latency.
module imem_ctrl import imem_pkg::*; #(
  parameter int unsigned ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned DATA_W   = IMEM_DATA_W,
  parameter int unsigned LOAD_LEN = 512,
  parameter int unsigned STARVE_N = 4
) (
  input logic   Clock,
  input logic   reset_n,
  imem_if.slave bus
);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              run;
  logic              wr_en;
  logic              wr_last;
  logic              fetch_gnt;
  logic              dbg_gnt;
  owner_t            owner;
  logic              err_q;
  logic [DATA_W-1:0] fetch_hold;
  logic [DATA_W-1:0] dbg_hold;

  assign run     = (state == S_RUN);
  // ld_ready is gated by reset so the loader sees no acceptance while held in reset.
  assign bus.ld_ready  = !run && reset_n;
  assign bus.boot_done = run;
  assign wr_en   = bus.ld_valid && bus.ld_ready;
  assign wr_last = bus.ld_last || (wr_ptr == ADDR_W'(LOAD_LEN - 1));

  // Boot-load write pointer and the one-way LOAD -> RUN transition.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_LOAD;
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (wr_last) begin
        state <= S_RUN;
      end
    end
  end

  assign bus.sram_csb0  = !wr_en;
  assign bus.sram_addr0 = wr_en ? wr_ptr : '0;
  assign bus.sram_din0  = wr_en ? bus.ld_data : '0;

  imem_rd_arb #(
    .STARVE_N(STARVE_N)
  ) u_arb (
    .clk       (Clock),
    .rst_n     (reset_n),
    .en        (run),
    .fetch_req (bus.fetch_req),
    .dbg_req   (bus.dbg_req),
    .fetch_gnt (fetch_gnt),
    .dbg_gnt   (dbg_gnt),
    .owner     (owner)
  );

  assign bus.fetch_gnt  = fetch_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.sram_csb1  = !(fetch_gnt || dbg_gnt);
  assign bus.sram_addr1 = dbg_gnt   ? bus.dbg_addr :
                          fetch_gnt ? bus.fetch_addr[ADDR_W-1:0] : '0;

  assign bus.fetch_valid = (owner == OWN_FETCH);
  assign bus.dbg_valid   = (owner == OWN_DBG);
  assign bus.addr_err    = bus.fetch_valid && err_q;

  // Read data is passed straight through in the valid cycle and held afterwards.
  assign bus.fetch_data = bus.fetch_valid ? bus.sram_dout1 : fetch_hold;
  assign bus.dbg_data   = bus.dbg_valid   ? bus.sram_dout1 : dbg_hold;

  // Remember out-of-range fetches and the last delivered word per requester.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q      <= 1'b0;
      fetch_hold <= '0;
      dbg_hold   <= '0;
    end else begin
      err_q <= fetch_gnt && (bus.fetch_addr[15:ADDR_W] != '0);
      if (bus.fetch_valid) begin
        fetch_hold <= bus.sram_dout1;
      end
      if (bus.dbg_valid) begin
        dbg_hold <= bus.sram_dout1;
      end
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Scoreboard bench for imem_ctrl: a behavioural model predicts acceptance,
// grants and read responses; a negedge monitor compares against the DUT.
module tb_imem_ctrl;

  localparam int unsigned LOAD_LEN = 512;
  localparam int unsigned STARVE_N = 4;

  typedef struct {
    bit          is_dbg;
    logic [15:0] data;
    bit          err;
    int unsigned cyc;
  } rd_t;

  logic clk;
  logic rst_n;

  imem_if bus ();

  imem_ctrl #(
    .ADDR_W   (9),
    .DATA_W   (16),
    .LOAD_LEN (LOAD_LEN),
    .STARVE_N (STARVE_N)
  ) dut (
    .Clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  // SRAM macro stand-in: synchronous write on port 0, registered read on port 1.
  logic [15:0] sram [0:511];
  always @(posedge clk) begin
    if (!bus.sram_csb0) sram[bus.sram_addr0] <= bus.sram_din0;
    if (!bus.sram_csb1) bus.sram_dout1 <= sram[bus.sram_addr1];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model state
  logic [15:0] ref_mem [0:511];
  bit          m_run;
  int unsigned m_ptr;
  int unsigned m_starve;
  rd_t         exp_q[$];
  logic [15:0] last_fd, last_dd;

  // Per-cycle expectations published by the driver
  bit          mon_on;
  bit          e_ld_ready, e_wr, e_fg, e_dg;
  logic [8:0]  e_addr0, e_addr1;
  logic [15:0] e_din0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic step(input bit lv, input logic [15:0] ld, input bit ll,
                      input bit fr, input logic [15:0] fa,
                      input bit dr, input logic [8:0] da);
    bit last;
    bus.ld_valid   = lv;
    bus.ld_data    = ld;
    bus.ld_last    = ll;
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    bus.dbg_req    = dr;
    bus.dbg_addr   = da;
    e_ld_ready = !m_run;
    e_wr       = lv && !m_run;
    e_addr0    = m_ptr[8:0];
    e_din0     = ld;
    e_dg       = m_run && dr && (!fr || m_starve == STARVE_N);
    e_fg       = m_run && fr && !e_dg;
    e_addr1    = e_dg ? da : fa[8:0];
    if (e_fg) exp_q.push_back('{is_dbg: 1'b0, data: ref_mem[fa[8:0]], err: (fa[15:9] != 7'd0), cyc: cyc});
    if (e_dg) exp_q.push_back('{is_dbg: 1'b1, data: ref_mem[da], err: 1'b0, cyc: cyc});
    mon_on = 1'b1;
    @(posedge clk);
    if (e_wr) begin
      ref_mem[m_ptr] = ld;
      last = ll || (m_ptr == LOAD_LEN - 1);
      m_ptr++;
      if (last) m_run = 1'b1;
    end
    if (!dr || e_dg) m_starve = 0;
    else if (e_fg && m_starve < STARVE_N) m_starve++;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 16'h0, 0, 0, 16'h0, 0, 9'h0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_run = 1'b0;
    m_ptr = 0;
    m_starve = 0;
    last_fd = 16'h0;
    last_dd = 16'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {bus.ld_ready, bus.boot_done, bus.fetch_gnt, bus.dbg_gnt,
                          bus.fetch_valid, bus.dbg_valid, bus.addr_err,
                          bus.sram_csb0, bus.sram_csb1}, 64'b000000011);
    chk({tag, "_addr"}, {bus.sram_addr0, bus.sram_addr1}, 64'h0);
    chk({tag, "_data"}, {bus.sram_din0, bus.fetch_data, bus.dbg_data}, 64'h0);
  endtask

  task automatic do_reset(input int unsigned n);
    mon_on = 1'b0;
    rst_n = 1'b0;
    bus.ld_valid = 0; bus.ld_last = 0; bus.fetch_req = 0; bus.dbg_req = 0;
    model_reset();
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    check_reset_outputs("rst");
    rst_n = 1'b1;
  endtask

  // Monitor: compares control outputs every cycle and pops read responses.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("ld_ready", bus.ld_ready, e_ld_ready);
      chk("boot_done", bus.boot_done, m_run);
      chk("csb0", bus.sram_csb0, !e_wr);
      if (e_wr) chk("wr_addr_data", {bus.sram_addr0, bus.sram_din0}, {e_addr0, e_din0});
      chk("gnt", {bus.fetch_gnt, bus.dbg_gnt}, {e_fg, e_dg});
      chk("csb1", bus.sram_csb1, !(e_fg || e_dg));
      if (e_fg || e_dg) chk("addr1", bus.sram_addr1, e_addr1);
      if (bus.fetch_valid || bus.dbg_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {bus.fetch_valid, bus.dbg_valid}, 64'h0);
        end else begin
          rd_t r;
          r = exp_q.pop_front();
          chk("rd_owner", {bus.fetch_valid, bus.dbg_valid}, {!r.is_dbg, r.is_dbg});
          if (r.is_dbg) begin
            chk("dbg_data", bus.dbg_data, r.data);
            last_dd = r.data;
          end else begin
            chk("fetch_data", bus.fetch_data, r.data);
            chk("addr_err", bus.addr_err, r.err);
            last_fd = r.data;
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc + 1 <= cyc) begin
        void'(exp_q.pop_front());
        chk("missing_valid", 64'h0, 64'h1);
      end
      if (!bus.fetch_valid) begin
        chk("fetch_hold", bus.fetch_data, last_fd);
        chk("addr_err_idle", bus.addr_err, 64'h0);
      end
      if (!bus.dbg_valid) chk("dbg_hold", bus.dbg_data, last_dd);
    end
  end

  initial begin
    bit          dbg_pend;
    logic [8:0]  dbg_a;
    logic [15:0] fa;
    logic [15:0] w;

    for (int unsigned i = 0; i < 512; i++) begin
      sram[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    mon_on = 1'b0;
    bus.ld_data = 16'h0; bus.fetch_addr = 16'h0; bus.dbg_addr = 9'h0;
    #1;
    do_reset(3);

    // Boot load of three words, one idle gap, ld_last on the third
    step(1, 16'h1111, 0, 0, 16'h0, 0, 9'h0);
    step(0, 16'h0,    0, 0, 16'h0, 0, 9'h0);
    step(1, 16'h2222, 0, 0, 16'h0, 0, 9'h0);
    step(1, 16'h3333, 1, 0, 16'h0, 0, 9'h0);
    step(1, 16'h4444, 0, 0, 16'h0, 0, 9'h0);
    idle(1);

    // Back-to-back fetches
    step(0, 16'h0, 0, 1, 16'h0000, 0, 9'h0);
    step(0, 16'h0, 0, 1, 16'h0001, 0, 9'h0);
    step(0, 16'h0, 0, 1, 16'h0002, 0, 9'h0);
    idle(2);

    // Starvation: fetch held while debug waits on address 2
    dbg_pend = 1'b1;
    for (int unsigned i = 0; i < 8 && dbg_pend; i++) begin
      step(0, 16'h0, 0, 1, 16'(i % 3), 1, 9'd2);
      if (e_dg) dbg_pend = 1'b0;
    end
    step(0, 16'h0, 0, 1, 16'h0001, 0, 9'h0);
    chk("starve_clr", dut.u_arb.starve_cnt, 64'h0);
    idle(1);

    // Out-of-range fetches
    step(0, 16'h0, 0, 1, 16'h0201, 0, 9'h0);
    step(0, 16'h0, 0, 1, 16'hFE02, 0, 9'h0);
    idle(2);

    // Reset while a fetch is in flight
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 16'h0001;
    e_wr = 0; e_ld_ready = 0; e_dg = 0; e_fg = 1; e_addr1 = 9'd1;
    exp_q.push_back('{is_dbg: 1'b0, data: ref_mem[1], err: 1'b0, cyc: cyc});
    #6;
    do_reset(2);
    chk("no_valid_after_rst", {bus.fetch_valid, bus.dbg_valid}, 64'h0);

    // Short reload: fetch during load ignored, restart at address 0, old image kept
    step(1, 16'hAAAA, 0, 1, 16'h0002, 1, 9'd2);
    step(1, 16'hBBBB, 1, 1, 16'h0002, 0, 9'd0);
    step(0, 16'h0, 0, 1, 16'h0002, 0, 9'h0);
    step(0, 16'h0, 0, 1, 16'h0000, 0, 9'h0);
    idle(2);

    // Full-length load without ld_last, fetches ignored during load
    do_reset(2);
    for (int unsigned n = 0; n < LOAD_LEN; ) begin
      if ($urandom_range(0, 3) == 0) begin
        step(0, 16'h0, 0, 1'($urandom_range(0, 1)), 16'($urandom), 0, 9'h0);
      end else begin
        w = 16'($urandom);
        step(1, w, 0, 1'($urandom_range(0, 1)), 16'($urandom), 0, 9'h0);
        n++;
      end
    end
    step(1, 16'hDEAD, 0, 0, 16'h0, 0, 9'h0);
    step(1, 16'hBEEF, 1, 0, 16'h0, 0, 9'h0);

    // Randomized run-phase traffic
    dbg_pend = 1'b0;
    dbg_a = 9'h0;
    for (int unsigned i = 0; i < 1500; i++) begin
      if (!dbg_pend && $urandom_range(0, 3) == 0) begin
        dbg_pend = 1'b1;
        dbg_a = 9'($urandom_range(0, 511));
      end
      fa = 16'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) fa = 16'($urandom);
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) != 0), fa, dbg_pend, dbg_a);
      if (e_dg) dbg_pend = 1'b0;
    end
    idle(3);
    chk("drain", exp_q.size(), 64'h0);

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
